// File: rtl/key_event_decoder.sv
// Key gesture decoder: classifies debounced key edges into short press, double click and long press.
// Define KEY_REPEAT_EN to emit periodic repeat_pulse while a long press is held.
module key_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned DCLICK_CYCLES = 15_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_flag,
    input  logic key_state,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic pressed
);

    localparam int unsigned CntW   = 26;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    if (LONG_CYCLES < 2 || LONG_CYCLES > CntMax || DCLICK_CYCLES < 2 || DCLICK_CYCLES > CntMax ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > CntMax) begin : g_param_check
        $error("key_event_decoder: cycle parameters must lie in 2..2^26-1");
    end

    // The event cycle itself is the first cycle of a timed phase, so the
    // registered count lags the elapsed phase length by one.
    localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYCLES - 2);
    localparam logic [CntW-1:0] DclickLast = CntW'(DCLICK_CYCLES - 2);
`ifdef KEY_REPEAT_EN
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPress1 = 3'd1,
        StWait2  = 3'd2,
        StPress2 = 3'd3,
        StLong   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            short_q, short_d;
    logic            dclick_q, dclick_d;
    logic            long_q, long_d;
    logic            pressed_q, pressed_d;
    logic            press_ev, release_ev;
`ifdef KEY_REPEAT_EN
    logic            repeat_q, repeat_d;
`endif

    assign press_ev   = key_flag & ~key_state;
    assign release_ev = key_flag & key_state;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        dclick_d = 1'b0;
        long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (press_ev) state_d = StPress1;
            end
            StPress1: begin
                if (release_ev) begin
                    state_d = StWait2;
                end else if (cnt_q == LongLast) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                end
            end
            StWait2: begin
                if (press_ev) begin
                    state_d = StPress2;
                end else if (cnt_q == DclickLast) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end
            end
            StPress2: begin
                if (release_ev) begin
                    state_d  = StIdle;
                    dclick_d = 1'b1;
                end else if (cnt_q == LongLast) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                end
            end
            StLong: begin
                if (release_ev) begin
                    state_d = StIdle;
                end
`ifdef KEY_REPEAT_EN
                else if (cnt_q == RepeatLast) begin
                    repeat_d = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = '0;
`ifdef KEY_REPEAT_EN
        end else if (repeat_d) begin
            cnt_d = '0;
`else
        end else if (cnt_q == CntW'(CntMax)) begin
            cnt_d = cnt_q;
`endif
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end

        pressed_d = (state_d == StPress1) || (state_d == StPress2) || (state_d == StLong);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            short_q   <= short_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            pressed_q <= pressed_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign short_press  = short_q;
    assign double_click = dclick_q;
    assign long_press   = long_q;
    assign pressed      = pressed_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG=20, DCLICK=10, REPEAT=5.
// Expected vectors are {pressed, repeat_pulse, long_press, double_click, short_press}.
module tb_key_event_decoder;

`ifdef KEY_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic key_flag = 1'b0;
    logic key_state = 1'b1;
    logic short_press, double_click, long_press, repeat_pulse, pressed;
    int   checks = 0;
    int   errors = 0;

    key_event_decoder #(
        .LONG_CYCLES  (20),
        .DCLICK_CYCLES(10),
        .REPEAT_CYCLES(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .short_press (short_press),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .pressed     (pressed)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ev(input logic p, input logic r, input logic l, input logic d,
                                      input logic s);
        return {p, r, l, d, s};
    endfunction

    task automatic check(input string tag, input int t, input logic [4:0] exp);
        logic [4:0] got;
        got = {pressed, repeat_pulse, long_press, double_click, short_press};
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d got=%b expected=%b", tag, t, got, exp);
        end
    endtask

    // Check this cycle's outputs, then drive this cycle's inputs and advance past the edge.
    task automatic cyc(input string tag, input int t, input logic f, input logic s,
                       input logic [4:0] exp);
        check(tag, t, exp);
        key_flag  = f;
        key_state = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2 reset = 1'b0;
        #1 check("reset_async", 0, 5'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", 0, 5'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single click: short_press lands 10 cycles after the release.
        for (int t = 0; t <= 25; t++)
            cyc("short", t, t == 0 || t == 5, t == 5,
                ev(t >= 1 && t <= 5, 1'b0, 1'b0, 1'b0, t == 15));

        // Double click inside the window.
        for (int t = 0; t <= 30; t++)
            cyc("double", t, t == 0 || t == 4 || t == 8 || t == 12, t == 4 || t == 12,
                ev((t >= 1 && t <= 4) || (t >= 9 && t <= 12), 1'b0, 1'b0, t == 13, 1'b0));

        // Long press held 40 cycles.
        for (int t = 0; t <= 50; t++)
            cyc("long", t, t == 0 || t == 40, t == 40,
                ev(t >= 1 && t <= 40, RepEn && (t == 25 || t == 30 || t == 35 || t == 40),
                   t == 20, 1'b0, 1'b0));

        // Second press on the last window cycle beats the timeout.
        for (int t = 0; t <= 30; t++)
            cyc("win_last", t, t == 0 || t == 3 || t == 12 || t == 15, t == 3 || t == 15,
                ev((t >= 1 && t <= 3) || (t >= 13 && t <= 15), 1'b0, 1'b0, t == 16, 1'b0));

        // Second press one cycle late: two separate short presses.
        for (int t = 0; t <= 35; t++)
            cyc("win_late", t, t == 0 || t == 3 || t == 13 || t == 16, t == 3 || t == 16,
                ev((t >= 1 && t <= 3) || (t >= 14 && t <= 16), 1'b0, 1'b0, 1'b0,
                   t == 13 || t == 26));

        // Duplicate press, unflagged level change and stray release are all ignored.
        for (int t = 0; t <= 35; t++)
            cyc("dup_press", t, t == 0 || t == 7 || t == 23 || t == 27,
                t == 10 || t == 23 || t == 27,
                ev(t >= 1 && t <= 23, 1'b0, t == 20, 1'b0, 1'b0));

        // Second press held long: long_press only, the first click is dropped.
        for (int t = 0; t <= 40; t++)
            cyc("press2_long", t, t == 0 || t == 2 || t == 5 || t == 30, t == 2 || t == 30,
                ev((t >= 1 && t <= 2) || (t >= 6 && t <= 30), RepEn && t == 30, t == 25,
                   1'b0, 1'b0));

        // Reset mid-press discards everything.
        for (int t = 0; t <= 9; t++)
            cyc("rst_press", t, t == 0, 1'b0, ev(t >= 1, 1'b0, 1'b0, 1'b0, 1'b0));
        check("rst_pre", 10, ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        #1 check("rst_async_mid", 10, 5'b0);
        repeat (3) @(posedge clk);
        #1 check("rst_held_mid", 13, 5'b0);
        reset = 1'b1;
        for (int t = 0; t <= 99; t++)
            cyc("post_rst", t, t == 50, 1'b1, 5'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
